writeback_reorder_unit: RTL and testbench
=========================================

# writeback_reorder_unit

In-order completion buffer at the far end of the dual-issue path. Allocates one tagged entry per instruction the issue stage steers into the branch and memory pipelines. Captures their results as they complete out of order, with the memory pipe taking a variable number of cycles. Retires entries to the register file strictly in program order, up to two per cycle.

## Interface
- `WIDTH`, 32, data width
- `DEPTH`, 8, entry count; power of 2, ≥4
- `TAG_W`, $clog2(DEPTH), tag width
- `clk` in 1, sole clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `flush` in 1, synchronous clear of all entries
- `alloc_valid` in 2, allocation request per slot; slot 0 is older
- `alloc_rd` in 2×5, destination register per slot
- `alloc_rf_we` in 2, slot writes the register file
- `alloc_ready` out 1, at least 2 free entries
- `alloc_tag` out 2×TAG_W, tag assigned to each slot (combinational)
- `br_done_valid` in 1, branch pipe result valid
- `br_done_tag` in TAG_W, tag of branch pipe result
- `br_done_data` in WIDTH, branch pipe result data
- `mem_done_valid` in 1, memory pipe result valid
- `mem_done_tag` in TAG_W, tag of memory pipe result
- `mem_done_data` in WIDTH, memory pipe result data
- `rf_we` out 2, register-file write enable per retire port
- `rf_waddr` out 2×5, register-file write address per retire port
- `rf_wdata` out 2×WIDTH, register-file write data per retire port
- `retire_count` out 2, entries retired at the last edge (0..2)

## Operation
- Circular buffer. State per entry: valid, done, rd, rf_we, data. `head` and `tail` pointers carry a wrap bit, TAG_W+1 bits each. `count = tail - head`.
- **Allocation**
  - Accepted when `alloc_ready` is high.
  - Valid slots take consecutive tail entries, slot 0 first.
  - `alloc_valid=2'b10` puts slot 1 at `tail`.
  - `alloc_tag[0]=tail[TAG_W-1:0]`.
  - `alloc_tag[1]` = tail+1 if slot 0 is valid, otherwise tail.
  - `tail` advances by popcount(alloc_valid).
- `alloc_ready = (DEPTH - count) >= 2`. It uses the registered count only; same-cycle retires do not raise it.
- **Completion**
  - Each valid done port sets `done` and writes `data` for its tag.
  - A tag whose entry is not valid is ignored.
  - If both ports carry the same tag (illegal), the branch port wins.
- **Retire**
  - If entry `head` is valid and done, it retires on port 0.
  - If it retires and entry `head+1` is also valid and done, that entry retires on port 1.
  - A retired entry is cleared to invalid/not done, and `head` advances by the retire count.
- `rf_we[i]` = entry rf_we AND rd≠0. Entries with rf_we=0 (stores, branches) still retire, with `rf_we[i]=0`.
- `alloc_rf_we` with rd=0 is legal; that entry never writes.
- **Flush**
  - Highest priority.
  - Clears all valid/done bits and sets head=tail=0.
  - Allocations, completions and retires in the flush cycle are discarded.
- **Reset**: all entries invalid, head=tail=0, `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `retire_count=0`. `alloc_ready` is therefore 1 after reset.

## Timing
- Completion sampled at edge E0 → done bit visible in the cycle after E0 → retire outputs registered at E1. Completion-to-RF-write latency is 2 edges.
- A tag may complete no earlier than the edge after its allocation edge.
- Retire outputs hold for exactly one cycle. `rf_we` is 0 in any cycle without a retire.
- Allocate and retire in the same cycle: `count` updates by +alloc −retire.
- Full buffer (`count=DEPTH`) still retires and accepts completions; it only blocks allocation.
- Pointer wrap: the index wraps modulo DEPTH. The wrap bit distinguishes full from empty.
- Flush mid-operation: `rf_we=0` from the edge after the flush cycle. A retire registered at the flush edge itself is suppressed.

## Configuration
- `RETIRE_DUAL_EN` defined: up to 2 retires per cycle, as above.
- `RETIRE_DUAL_EN` undefined:
  - At most 1 retire per cycle.
  - `rf_we[1]`, `rf_waddr[1]` and `rf_wdata[1]` are tied to 0.
  - `retire_count` ≤ 1.
  - All other behaviour is unchanged.

## Test plan
- **Reset, then allocate**: allocate `2'b11` (rd=5, rd=6, we=1) → tags 0 and 1. Complete mem tag1=0xBB at cycle 3 → no retire. Complete br tag0=0xAA at cycle 5 → 2 edges later `rf_we=2'b11`, waddr 5/6, wdata 0xAA/0xBB, retire_count=2 (1 without the macro, with tag1 on the next cycle).
- **Fill the buffer**: alloc `2'b11` ×4 with DEPTH=8 → `alloc_ready=0` at count=8. Retire 2 → ready=1 next cycle. The next alloc tags are 0 and 1 (wrap).
- **rd=0 and non-writing entry**: alloc rd=0 we=1, then a store with we=0. Complete both → both retire, `rf_we=2'b00`, retire_count=2.
- **Same-tag collision**: br and mem both tag 2, data 0x11/0x22 → retires 0x11.
- **Flush with 3 outstanding entries, 1 done**: flush → no retire thereafter, count=0, `alloc_ready=1`, next alloc tag=0. A completion for an old tag is ignored.
- **Async reset mid-retire**: assert `rst_n=0` between edges while `rf_we=2'b11` → outputs go to 0 immediately, with no clock edge.

Source files
------------

// File: rtl/writeback_reorder_unit.sv
// In-order completion buffer for the branch and memory pipes; retires to the register file in program order.
// Build option: define RETIRE_DUAL_EN to allow two retires per cycle (default is one).
module writeback_reorder_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [1:0]              alloc_valid,
    input  logic [1:0][4:0]         alloc_rd,
    input  logic [1:0]              alloc_rf_we,
    output logic                    alloc_ready,
    output logic [1:0][TAG_W-1:0]   alloc_tag,
    input  logic                    br_done_valid,
    input  logic [TAG_W-1:0]        br_done_tag,
    input  logic [WIDTH-1:0]        br_done_data,
    input  logic                    mem_done_valid,
    input  logic [TAG_W-1:0]        mem_done_tag,
    input  logic [WIDTH-1:0]        mem_done_data,
    output logic [1:0]              rf_we,
    output logic [1:0][4:0]         rf_waddr,
    output logic [1:0][WIDTH-1:0]   rf_wdata,
    output logic [1:0]              retire_count
);

`ifdef RETIRE_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    localparam logic [TAG_W:0] DEPTH_P = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   done_q;
    logic [DEPTH-1:0]   we_q;
    logic [4:0]         rd_q   [DEPTH];
    logic [WIDTH-1:0]   data_q [DEPTH];

    logic [TAG_W:0]     head_q, tail_q;
    logic [TAG_W:0]     count, free, head_next, tail_next;
    logic [TAG_W-1:0]   head_idx, head1_idx;
    logic               ret0, ret1;

    // Pointers carry a wrap bit so a full buffer is distinguishable from an empty one.
    assign count       = tail_q - head_q;
    assign free        = DEPTH_P - count;
    assign alloc_ready = (free >= (TAG_W+1)'(2));

    assign alloc_tag[0] = tail_q[TAG_W-1:0];
    assign alloc_tag[1] = alloc_valid[0] ? tail_q[TAG_W-1:0] + TAG_W'(1) : tail_q[TAG_W-1:0];
    assign tail_next    = tail_q + (TAG_W+1)'(alloc_valid[0]) + (TAG_W+1)'(alloc_valid[1]);

    assign head_idx  = head_q[TAG_W-1:0];
    assign head1_idx = head_idx + TAG_W'(1);
    assign ret0      = valid_q[head_idx] & done_q[head_idx];
    assign ret1      = DUAL & ret0 & valid_q[head1_idx] & done_q[head1_idx];
    assign head_next = head_q + (TAG_W+1)'(ret0) + (TAG_W+1)'(ret1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            done_q       <= '0;
            we_q         <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            rf_we        <= '0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            retire_count <= '0;
        end else if (flush) begin
            valid_q      <= '0;
            done_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            rf_we        <= '0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            retire_count <= '0;
        end else begin
            // Branch port is written last so it wins a same-tag collision.
            if (mem_done_valid && valid_q[mem_done_tag]) begin
                done_q[mem_done_tag] <= 1'b1;
                data_q[mem_done_tag] <= mem_done_data;
            end
            if (br_done_valid && valid_q[br_done_tag]) begin
                done_q[br_done_tag] <= 1'b1;
                data_q[br_done_tag] <= br_done_data;
            end

            rf_we    <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            if (ret0) begin
                valid_q[head_idx] <= 1'b0;
                done_q[head_idx]  <= 1'b0;
                rf_we[0]          <= we_q[head_idx] & (rd_q[head_idx] != 5'd0);
                rf_waddr[0]       <= rd_q[head_idx];
                rf_wdata[0]       <= data_q[head_idx];
            end
            if (ret1) begin
                valid_q[head1_idx] <= 1'b0;
                done_q[head1_idx]  <= 1'b0;
                rf_we[1]           <= we_q[head1_idx] & (rd_q[head1_idx] != 5'd0);
                rf_waddr[1]        <= rd_q[head1_idx];
                rf_wdata[1]        <= data_q[head1_idx];
            end
            retire_count <= {ret1, ret0 & ~ret1};
            head_q       <= head_next;

            // Allocation targets free entries only, so it never collides with a retire.
            if (alloc_ready) begin
                if (alloc_valid[0]) begin
                    valid_q[alloc_tag[0]] <= 1'b1;
                    done_q[alloc_tag[0]]  <= 1'b0;
                    we_q[alloc_tag[0]]    <= alloc_rf_we[0];
                    rd_q[alloc_tag[0]]    <= alloc_rd[0];
                end
                if (alloc_valid[1]) begin
                    valid_q[alloc_tag[1]] <= 1'b1;
                    done_q[alloc_tag[1]]  <= 1'b0;
                    we_q[alloc_tag[1]]    <= alloc_rf_we[1];
                    rd_q[alloc_tag[1]]    <= alloc_rd[1];
                end
                tail_q <= tail_next;
            end
        end
    end

endmodule

// File: tb/tb_writeback_reorder_unit.sv
// Directed bench for writeback_reorder_unit: vector table plus hand sequences for fill, flush and async reset.
// Expected values follow the RETIRE_DUAL_EN setting used for the build.
module tb_writeback_reorder_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int TAG_W = 3;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush;
    logic [1:0]            alloc_valid;
    logic [1:0][4:0]       alloc_rd;
    logic [1:0]            alloc_rf_we;
    logic                  alloc_ready;
    logic [1:0][TAG_W-1:0] alloc_tag;
    logic                  br_done_valid;
    logic [TAG_W-1:0]      br_done_tag;
    logic [WIDTH-1:0]      br_done_data;
    logic                  mem_done_valid;
    logic [TAG_W-1:0]      mem_done_tag;
    logic [WIDTH-1:0]      mem_done_data;
    logic [1:0]            rf_we;
    logic [1:0][4:0]       rf_waddr;
    logic [1:0][WIDTH-1:0] rf_wdata;
    logic [1:0]            retire_count;

    int checks = 0;
    int errors = 0;

    writeback_reorder_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_rf_we(alloc_rf_we),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .br_done_valid(br_done_valid), .br_done_tag(br_done_tag), .br_done_data(br_done_data),
        .mem_done_valid(mem_done_valid), .mem_done_tag(mem_done_tag), .mem_done_data(mem_done_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  av;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [1:0]  we;
        logic        bv;
        logic [2:0]  bt;
        logic [31:0] bd;
        logic        mv;
        logic [2:0]  mt;
        logic [31:0] md;
        logic [2:0]  t0;
        logic [2:0]  t1;
        logic [1:0]  ewe;
        logic [4:0]  ea0;
        logic [31:0] ed0;
        logic [1:0]  erc;
    } vec_t;

    vec_t vt [11];

    function automatic vec_t mk(input logic [1:0] av, input logic [4:0] rd0, input logic [4:0] rd1,
                                input logic [1:0] we, input logic bv, input logic [2:0] bt,
                                input logic [31:0] bd, input logic mv, input logic [2:0] mt,
                                input logic [31:0] md, input logic [2:0] t0, input logic [2:0] t1,
                                input logic [1:0] ewe, input logic [4:0] ea0, input logic [31:0] ed0,
                                input logic [1:0] erc);
        vec_t v;
        v.av = av; v.rd0 = rd0; v.rd1 = rd1; v.we = we;
        v.bv = bv; v.bt = bt; v.bd = bd; v.mv = mv; v.mt = mt; v.md = md;
        v.t0 = t0; v.t1 = t1; v.ewe = ewe; v.ea0 = ea0; v.ed0 = ed0; v.erc = erc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        flush          = 1'b0;
        alloc_valid    = 2'b00;
        alloc_rd       = '0;
        alloc_rf_we    = 2'b00;
        br_done_valid  = 1'b0;
        br_done_tag    = '0;
        br_done_data   = '0;
        mem_done_valid = 1'b0;
        mem_done_tag   = '0;
        mem_done_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic alloc2(input logic [1:0] av, input logic [4:0] r0, input logic [4:0] r1,
                          input logic [1:0] we);
        alloc_valid    = av;
        alloc_rd[0]    = r0;
        alloc_rd[1]    = r1;
        alloc_rf_we    = we;
    endtask

    task automatic post(input string name, input logic [1:0] we, input logic [1:0] rc);
        chk({name, " rf_we"}, 64'(rf_we), 64'(we));
        chk({name, " retire_count"}, 64'(retire_count), 64'(rc));
    endtask

    task automatic port(input string name, input int p, input logic [4:0] a, input logic [31:0] d);
        chk({name, " rf_waddr"}, 64'(rf_waddr[p]), 64'(a));
        chk({name, " rf_wdata"}, 64'(rf_wdata[p]), 64'(d));
    endtask

    initial begin
        idle_in();

        // Reset state
        do_reset();
        post("reset", 2'b00, 2'd0);
        chk("reset rf_waddr", 64'(rf_waddr), 64'h0);
        chk("reset rf_wdata", 64'(rf_wdata), 64'h0);
        chk("reset alloc_ready", 64'(alloc_ready), 64'h1);
        chk("reset alloc_tag0", 64'(alloc_tag[0]), 64'h0);

        // Single-retire vector table: rd=0, store, collision, stale tag
        vt[0]  = mk(2'b01, 5'd5, 5'd0, 2'b01, 1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 32'h0,    3'd0, 3'd1, 2'b00, 5'd0, 32'h0,    2'd0);
        vt[1]  = mk(2'b10, 5'd0, 5'd7, 2'b10, 1'b1, 3'd0, 32'hAA,   1'b0, 3'd0, 32'h0,    3'd1, 3'd1, 2'b00, 5'd0, 32'h0,    2'd0);
        vt[2]  = mk(2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 32'h0,    3'd2, 3'd2, 2'b01, 5'd5, 32'hAA,   2'd1);
        vt[3]  = mk(2'b11, 5'd0, 5'd9, 2'b01, 1'b0, 3'd0, 32'h0,    1'b1, 3'd1, 32'h1234, 3'd2, 3'd3, 2'b00, 5'd0, 32'h0,    2'd0);
        vt[4]  = mk(2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 32'h0,    3'd4, 3'd4, 2'b01, 5'd7, 32'h1234, 2'd1);
        vt[5]  = mk(2'b00, 5'd0, 5'd0, 2'b00, 1'b1, 3'd2, 32'h55,   1'b0, 3'd0, 32'h0,    3'd4, 3'd4, 2'b00, 5'd0, 32'h0,    2'd0);
        vt[6]  = mk(2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 32'h0,    3'd4, 3'd4, 2'b00, 5'd0, 32'h55,   2'd1);
        vt[7]  = mk(2'b00, 5'd0, 5'd0, 2'b00, 1'b1, 3'd3, 32'h11,   1'b1, 3'd3, 32'h22,   3'd4, 3'd4, 2'b00, 5'd0, 32'h0,    2'd0);
        vt[8]  = mk(2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 32'h0,    3'd4, 3'd4, 2'b00, 5'd9, 32'h11,   2'd1);
        vt[9]  = mk(2'b00, 5'd0, 5'd0, 2'b00, 1'b1, 3'd5, 32'h77,   1'b0, 3'd0, 32'h0,    3'd4, 3'd4, 2'b00, 5'd0, 32'h0,    2'd0);
        vt[10] = mk(2'b00, 5'd0, 5'd0, 2'b00, 1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 32'h0,    3'd4, 3'd4, 2'b00, 5'd0, 32'h0,    2'd0);

        for (int i = 0; i < 11; i++) begin
            alloc2(vt[i].av, vt[i].rd0, vt[i].rd1, vt[i].we);
            br_done_valid  = vt[i].bv;
            br_done_tag    = vt[i].bt;
            br_done_data   = vt[i].bd;
            mem_done_valid = vt[i].mv;
            mem_done_tag   = vt[i].mt;
            mem_done_data  = vt[i].md;
            #1;
            chk($sformatf("v%0d alloc_ready", i), 64'(alloc_ready), 64'h1);
            chk($sformatf("v%0d alloc_tag0", i), 64'(alloc_tag[0]), 64'(vt[i].t0));
            chk($sformatf("v%0d alloc_tag1", i), 64'(alloc_tag[1]), 64'(vt[i].t1));
            tick();
            post($sformatf("v%0d", i), vt[i].ewe, vt[i].erc);
            if (vt[i].erc != 2'd0)
                port($sformatf("v%0d p0", i), 0, vt[i].ea0, vt[i].ed0);
        end
        idle_in();

        // Out-of-order pair: younger completes first, both retire after the older completes
        do_reset();
        alloc2(2'b11, 5'd5, 5'd6, 2'b11);
        #1;
        chk("pair alloc_tag0", 64'(alloc_tag[0]), 64'h0);
        chk("pair alloc_tag1", 64'(alloc_tag[1]), 64'h1);
        tick();
        idle_in();
        tick();
        mem_done_valid = 1'b1; mem_done_tag = 3'd1; mem_done_data = 32'hBB;
        tick();
        idle_in();
        post("pair younger done", 2'b00, 2'd0);
        tick();
        post("pair wait", 2'b00, 2'd0);
        br_done_valid = 1'b1; br_done_tag = 3'd0; br_done_data = 32'hAA;
        tick();
        idle_in();
        post("pair E0", 2'b00, 2'd0);
        tick();
`ifdef RETIRE_DUAL_EN
        post("pair E1", 2'b11, 2'd2);
        port("pair p0", 0, 5'd5, 32'hAA);
        port("pair p1", 1, 5'd6, 32'hBB);
`else
        post("pair E1", 2'b01, 2'd1);
        port("pair p0", 0, 5'd5, 32'hAA);
        tick();
        post("pair E2", 2'b01, 2'd1);
        port("pair E2 p0", 0, 5'd6, 32'hBB);
`endif
        tick();
        post("pair after", 2'b00, 2'd0);

        // Fill to DEPTH, blocked allocation, retire, wrap
        do_reset();
        for (int k = 0; k < 4; k++) begin
            alloc2(2'b11, 5'(2*k+1), 5'(2*k+2), 2'b11);
            #1;
            chk($sformatf("fill%0d ready", k), 64'(alloc_ready), 64'h1);
            chk($sformatf("fill%0d tag1", k), 64'(alloc_tag[1]), 64'(2*k+1));
            tick();
        end
        chk("full ready", 64'(alloc_ready), 64'h0);
        alloc2(2'b11, 5'd20, 5'd21, 2'b11);
        br_done_valid  = 1'b1; br_done_tag  = 3'd0; br_done_data  = 32'h10;
        mem_done_valid = 1'b1; mem_done_tag = 3'd1; mem_done_data = 32'h20;
        tick();
        idle_in();
        post("full completion edge", 2'b00, 2'd0);
        tick();
`ifdef RETIRE_DUAL_EN
        post("full retire", 2'b11, 2'd2);
        port("full p1", 1, 5'd2, 32'h20);
`else
        post("full retire a", 2'b01, 2'd1);
        chk("full ready after one", 64'(alloc_ready), 64'h0);
        tick();
        post("full retire b", 2'b01, 2'd1);
        port("full b p0", 0, 5'd2, 32'h20);
`endif
        chk("full ready after two", 64'(alloc_ready), 64'h1);
        alloc2(2'b11, 5'd10, 5'd11, 2'b11);
        #1;
        chk("wrap tag0", 64'(alloc_tag[0]), 64'h0);
        chk("wrap tag1", 64'(alloc_tag[1]), 64'h1);
        tick();
        idle_in();
        chk("refull ready", 64'(alloc_ready), 64'h0);

        // Flush with three outstanding, head done; retire at the flush edge is suppressed
        do_reset();
        alloc2(2'b11, 5'd3, 5'd4, 2'b11);
        tick();
        alloc2(2'b01, 5'd5, 5'd0, 2'b01);
        tick();
        idle_in();
        br_done_valid = 1'b1; br_done_tag = 3'd0; br_done_data = 32'hAA;
        tick();
        idle_in();
        flush = 1'b1;
        alloc2(2'b11, 5'd7, 5'd8, 2'b11);
        mem_done_valid = 1'b1; mem_done_tag = 3'd1; mem_done_data = 32'hCC;
        tick();
        idle_in();
        post("flush edge", 2'b00, 2'd0);
        chk("flush ready", 64'(alloc_ready), 64'h1);
        chk("flush tag0", 64'(alloc_tag[0]), 64'h0);
        mem_done_valid = 1'b1; mem_done_tag = 3'd1; mem_done_data = 32'hDEAD;
        tick();
        idle_in();
        post("flush stale", 2'b00, 2'd0);
        alloc2(2'b11, 5'd3, 5'd4, 2'b11);
        #1;
        chk("post-flush tag0", 64'(alloc_tag[0]), 64'h0);
        chk("post-flush tag1", 64'(alloc_tag[1]), 64'h1);
        tick();
        idle_in();
        post("post-flush alloc", 2'b00, 2'd0);
        br_done_valid = 1'b1; br_done_tag = 3'd0; br_done_data = 32'h33;
        tick();
        idle_in();
        post("post-flush E0", 2'b00, 2'd0);
        tick();
        post("post-flush retire", 2'b01, 2'd1);
        port("post-flush p0", 0, 5'd3, 32'h33);
        tick();
        post("post-flush tag1 pending", 2'b00, 2'd0);

        // Asynchronous reset while retire outputs are active
        do_reset();
        alloc2(2'b11, 5'd5, 5'd6, 2'b11);
        tick();
        idle_in();
        br_done_valid  = 1'b1; br_done_tag  = 3'd0; br_done_data  = 32'h1;
        mem_done_valid = 1'b1; mem_done_tag = 3'd1; mem_done_data = 32'h2;
        tick();
        idle_in();
        tick();
`ifdef RETIRE_DUAL_EN
        chk("areset pre rf_we", 64'(rf_we), 64'h3);
`else
        chk("areset pre rf_we", 64'(rf_we), 64'h1);
`endif
        #1 rst_n = 1'b0;
        #1;
        post("areset", 2'b00, 2'd0);
        chk("areset rf_waddr", 64'(rf_waddr), 64'h0);
        chk("areset rf_wdata", 64'(rf_wdata), 64'h0);
        #1 rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
